// File: rtl/io_interrupt_ctrl.sv
// I/O and interrupt resources of the basic computer: INPR/OUTR, FGI/FGO, IEN, R.
// Also runs the device handshakes and sequences the RT0..RT2 interrupt cycle.
module io_interrupt_ctrl #(
    parameter int                IO_W      = 8,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] SAVE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_exec,
    input  logic [5:0]        io_op,
    input  logic [IO_W-1:0]   ac_low,
    input  logic              r_sample,
    input  logic              cycle_start,
    input  logic              in_valid,
    input  logic [IO_W-1:0]   in_data,
    output logic              in_ready,
    output logic [IO_W-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IO_W-1:0]   inpr,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              r,
    output logic              skip,
    output logic              int_active,
    output logic [2:0]        rt,
    output logic [ADDR_W-1:0] save_addr
);

    // One-hot encoding so the state register drives rt directly.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_RT0  = 3'b001,
        ST_RT1  = 3'b010,
        ST_RT2  = 3'b100
    } state_t;

    state_t          r_state;
    logic [IO_W-1:0] r_inpr;
    logic [IO_W-1:0] r_outr;
    logic            r_fgi;
    logic            r_fgo;
    logic            r_ien;
    logic            r_r;

    logic w_int_active;
    logic w_exec;
    logic w_inp;
    logic w_out;
    logic w_ski;
    logic w_sko;
    logic w_ion;
    logic w_iof;
    logic w_in_accept;
    logic w_out_done;
    logic w_r_set;

    assign w_int_active = (r_state != ST_IDLE);
    assign w_exec       = io_exec & ~w_int_active;
    assign w_inp        = w_exec & io_op[5];
    assign w_out        = w_exec & io_op[4];
    assign w_ski        = w_exec & io_op[3];
    assign w_sko        = w_exec & io_op[2];
    assign w_ion        = w_exec & io_op[1];
    assign w_iof        = w_exec & io_op[0];
    assign w_in_accept  = in_valid & ~r_fgi;
    assign w_out_done   = out_ready & ~r_fgo & ~w_out;
    assign w_r_set      = r_sample & ~w_int_active & r_ien & (r_fgi | r_fgo);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_inpr  <= '0;
            r_outr  <= '0;
            r_fgi   <= 1'b0;
            r_fgo   <= 1'b1;
            r_ien   <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            // A device accept in the same cycle as INP leaves the flag set.
            if (w_in_accept) begin
                r_inpr <= in_data;
                r_fgi  <= 1'b1;
            end else if (w_inp) begin
                r_fgi  <= 1'b0;
            end

            if (w_out) begin
                r_outr <= ac_low;
                r_fgo  <= 1'b0;
            end else if (w_out_done) begin
                r_fgo  <= 1'b1;
            end

            if (r_state == ST_RT2) begin
                r_ien <= 1'b0;
            end else if (w_iof) begin
                r_ien <= 1'b0;
            end else if (w_ion) begin
                r_ien <= 1'b1;
            end

            if (r_state == ST_RT2) begin
                r_r <= 1'b0;
            end else if (w_r_set) begin
                r_r <= 1'b1;
            end

            case (r_state)
                ST_IDLE: if (cycle_start && r_r) r_state <= ST_RT0;
                ST_RT0:  r_state <= ST_RT1;
                ST_RT1:  r_state <= ST_RT2;
                ST_RT2:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign skip       = (w_ski & r_fgi) | (w_sko & r_fgo);
    assign int_active = w_int_active;
    assign rt         = r_state;
    assign inpr       = r_inpr;
    assign out_data   = r_outr;
    assign fgi        = r_fgi;
    assign fgo        = r_fgo;
    assign ien        = r_ien;
    assign r          = r_r;
    assign in_ready   = ~r_fgi;
    assign out_valid  = ~r_fgo;
    assign save_addr  = SAVE_ADDR;

endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// Table-driven bench for io_interrupt_ctrl plus a hand-written interrupt timing sequence.
module tb_io_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset, io_exec, r_sample, cycle_start, in_valid, out_ready;
    logic [5:0]  io_op;
    logic [7:0]  ac_low, in_data, out_data, inpr;
    logic        in_ready, out_valid, fgi, fgo, ien, r, skip, int_active;
    logic [2:0]  rt;
    logic [11:0] save_addr;

    always #5 clk = ~clk;

    io_interrupt_ctrl #(.IO_W(8), .ADDR_W(12), .SAVE_ADDR(12'h000)) dut (
        .clk(clk), .reset(reset), .io_exec(io_exec), .io_op(io_op), .ac_low(ac_low),
        .r_sample(r_sample), .cycle_start(cycle_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .inpr(inpr), .fgi(fgi),
        .fgo(fgo), .ien(ien), .r(r), .skip(skip), .int_active(int_active),
        .rt(rt), .save_addr(save_addr)
    );

    localparam logic [5:0] NOP = 6'b000000, INP = 6'b100000, OUT = 6'b010000,
                           SKI = 6'b001000, SKO = 6'b000100, ION = 6'b000010,
                           IOF = 6'b000001;

    typedef struct packed {
        logic       rst;
        logic       ex;
        logic [5:0] op;
        logic [7:0] ac;
        logic       rs;
        logic       cs;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_skip;
        logic       e_fgi;
        logic       e_fgo;
        logic       e_ien;
        logic       e_r;
        logic [2:0] e_rt;
        logic [7:0] e_inpr;
        logic [7:0] e_outr;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_fail    = 0;

    function automatic vec_t mk(logic rst, logic ex, logic [5:0] op, logic [7:0] ac,
                                logic rs, logic cs, logic iv, logic [7:0] id, logic ordy,
                                logic e_skip, logic e_fgi, logic e_fgo, logic e_ien,
                                logic e_r, logic [2:0] e_rt, logic [7:0] e_inpr,
                                logic [7:0] e_outr);
        vec_t v;
        v = '{rst, ex, op, ac, rs, cs, iv, id, ordy,
              e_skip, e_fgi, e_fgo, e_ien, e_r, e_rt, e_inpr, e_outr};
        return v;
    endfunction

    task automatic drive_idle();
        reset = 0; io_exec = 0; io_op = NOP; ac_low = 0; r_sample = 0;
        cycle_start = 0; in_valid = 0; in_data = 0; out_ready = 0;
    endtask

    task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        drive_idle();
        //          rst ex op       ac     rs cs iv id     ordy | skip fgi fgo ien r rt      inpr   outr
        vecs.push_back(mk(1, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00)); // 0 reset
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 1, 8'hA5, 0,   0, 1, 1, 0, 0, 3'b000, 8'hA5, 8'h00)); // 1 accept
        vecs.push_back(mk(0, 1, SKI, 8'h00, 0, 0, 0, 8'h00, 0,   1, 1, 1, 0, 0, 3'b000, 8'hA5, 8'h00)); // 2
        vecs.push_back(mk(0, 1, INP, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h00)); // 3
        vecs.push_back(mk(0, 1, SKI, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h00)); // 4
        vecs.push_back(mk(0, 1, OUT, 8'h3C, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 3'b000, 8'hA5, 8'h3C)); // 5
        vecs.push_back(mk(0, 1, SKO, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 3'b000, 8'hA5, 8'h3C)); // 6
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 1,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h3C)); // 7
        vecs.push_back(mk(0, 1, SKO, 8'h00, 0, 0, 0, 8'h00, 0,   1, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h3C)); // 8
        vecs.push_back(mk(0, 1, OUT, 8'h5A, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 3'b000, 8'hA5, 8'h5A)); // 9
        vecs.push_back(mk(0, 1, OUT, 8'h77, 0, 0, 0, 8'h00, 1,   0, 0, 0, 0, 0, 3'b000, 8'hA5, 8'h77)); // 10 OUT beats ready
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 1,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h77)); // 11
        vecs.push_back(mk(0, 0, NOP, 8'h00, 1, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h77)); // 12 ien=0
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 1, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'hA5, 8'h77)); // 13
        vecs.push_back(mk(0, 1, ION, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 1, 0, 3'b000, 8'hA5, 8'h77)); // 14
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 1, 8'hC3, 0,   0, 1, 1, 1, 0, 3'b000, 8'hC3, 8'h77)); // 15
        vecs.push_back(mk(0, 0, NOP, 8'h00, 1, 0, 0, 8'h00, 0,   0, 1, 1, 1, 1, 3'b000, 8'hC3, 8'h77)); // 16 r set
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 1, 0, 8'h00, 0,   0, 1, 1, 1, 1, 3'b001, 8'hC3, 8'h77)); // 17 RT0
        vecs.push_back(mk(0, 1, 6'b001011, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 1, 1, 1, 3'b010, 8'hC3, 8'h77)); // 18 exec ignored
        vecs.push_back(mk(0, 0, NOP, 8'h00, 1, 1, 1, 8'h99, 0,   0, 1, 1, 1, 1, 3'b100, 8'hC3, 8'h77)); // 19
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 1, 0, 0, 3'b000, 8'hC3, 8'h77)); // 20 RT2 exit
        vecs.push_back(mk(0, 1, 6'b000011, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 3'b000, 8'hC3, 8'h77)); // 21 ION+IOF
        vecs.push_back(mk(0, 1, ION, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 1, 1, 0, 3'b000, 8'hC3, 8'h77)); // 22
        vecs.push_back(mk(0, 1, IOF, 8'h00, 0, 0, 0, 8'h00, 0,   0, 1, 1, 0, 0, 3'b000, 8'hC3, 8'h77)); // 23
        vecs.push_back(mk(0, 1, INP, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'hC3, 8'h77)); // 24
        vecs.push_back(mk(0, 1, INP, 8'h00, 0, 0, 1, 8'hE7, 0,   0, 1, 1, 0, 0, 3'b000, 8'hE7, 8'h77)); // 25 set wins
        vecs.push_back(mk(0, 1, 6'b010010, 8'h11, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 3'b000, 8'hE7, 8'h11)); // 26 OUT+ION
        vecs.push_back(mk(0, 0, NOP, 8'h00, 1, 0, 0, 8'h00, 0,   0, 1, 0, 1, 1, 3'b000, 8'hE7, 8'h11)); // 27
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 1, 0, 8'h00, 0,   0, 1, 0, 1, 1, 3'b001, 8'hE7, 8'h11)); // 28
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 1,   0, 1, 1, 1, 1, 3'b010, 8'hE7, 8'h11)); // 29 handshake in RT
        vecs.push_back(mk(1, 0, NOP, 8'h00, 0, 0, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00)); // 30 reset in RT1
        vecs.push_back(mk(0, 0, NOP, 8'h00, 0, 1, 0, 8'h00, 0,   0, 0, 1, 0, 0, 3'b000, 8'h00, 8'h00)); // 31

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; io_exec = v.ex; io_op = v.op; ac_low = v.ac; r_sample = v.rs;
            cycle_start = v.cs; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
            #1;
            check1($sformatf("v%0d skip", i), {31'd0, skip}, {31'd0, v.e_skip});
            @(posedge clk);
            #1;
            check1($sformatf("v%0d flags{fgi,fgo,ien,r,rt,act,in_rdy,out_vld}", i),
                   {24'd0, fgi, fgo, ien, r, rt[2:0], int_active} + {30'd0, in_ready, out_valid} * 32'h100,
                   {24'd0, v.e_fgi, v.e_fgo, v.e_ien, v.e_r, v.e_rt, |v.e_rt}
                       + {30'd0, ~v.e_fgi, ~v.e_fgo} * 32'h100);
            check1($sformatf("v%0d inpr/outr", i), {16'd0, inpr, out_data}, {16'd0, v.e_inpr, v.e_outr});
            check1($sformatf("v%0d save_addr", i), {20'd0, save_addr}, 32'h0);
        end

        // Interrupt via FGO alone: ION, sample, then measure the RT window length.
        @(negedge clk); drive_idle(); io_exec = 1; io_op = ION;
        @(negedge clk); drive_idle(); r_sample = 1;
        @(negedge clk); drive_idle();
        check1("seq r set by fgo", {31'd0, r}, 32'd1);
        cycle_start = 1;
        @(posedge clk); #1;
        cycle_start = 0;
        check1("seq int_active 1 clk after cycle_start", {29'd0, rt, int_active} , {29'd0, 3'b001, 1'b1});
        begin
            int cnt;
            int guard;
            cnt = 0;
            guard = 0;
            while (int_active && guard < 10) begin
                cnt++;
                guard++;
                @(posedge clk); #1;
            end
            check1("seq int_active duration", cnt, 3);
        end
        check1("seq ien/r cleared", {30'd0, ien, r}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
